// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: credit-based request issue, in-order response buffer,
// valid/ready fetch port to the core and redirect flush with stale-response discard.
module inst_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_discard_cnt,
    output logic [31:0] perf_starve_cnt
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_L = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_C   = CW'(1'b1);
    localparam logic [PW-1:0]   ZERO_P  = {PW{1'b0}};
    localparam logic [PW-1:0]   ONE_P   = PW'(1'b1);

    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_inst_q [DEPTH];
    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   fetch_inst_q, fetch_inst_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          inst_ready_q;
    logic [31:0]   perf_req_q, perf_req_d;
    logic [31:0]   perf_disc_q, perf_disc_d;
    logic [31:0]   perf_starve_q, perf_starve_d;

    logic          credit_s;
    logic          req_acc_s;
    logic          resp_acc_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   target_s;

    // Space is reserved at request time, so buffered plus in-flight never exceeds DEPTH.
    assign credit_s       = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_L;
    assign Inst_Req_Valid = rst & credit_s & ~redirect_valid;
    assign fetch_valid    = (count_q != ZERO_C) & ~redirect_valid;
    assign req_acc_s      = Inst_Req_Valid & Inst_Req_Ready;
    // Responses with nothing in flight (e.g. straddling a reset) are not tracked.
    assign resp_acc_s     = Inst_Valid & inst_ready_q & (outstanding_q != ZERO_C);
    assign drop_s         = resp_acc_s & (redirect_valid | (discard_q != ZERO_C));
    assign push_s         = resp_acc_s & ~drop_s;
    assign pop_s          = fetch_valid & fetch_ready;
    assign target_s       = {redirect_pc[31:2], 2'b00};

    assign PC               = req_pc_q;
    assign Inst_Ready       = inst_ready_q;
    assign fetch_inst       = fetch_inst_q;
    assign fetch_pc         = fetch_pc_q;
    assign perf_req_cnt     = perf_req_q;
    assign perf_discard_cnt = perf_disc_q;
    assign perf_starve_cnt  = perf_starve_q;

    // Next-state for PCs, credit/discard tracking, FIFO pointers and counters.
    always_comb begin
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + (req_acc_s ? ONE_C : ZERO_C)
                                      - (resp_acc_s ? ONE_C : ZERO_C);
        perf_req_d    = perf_req_q + {31'd0, req_acc_s};
        perf_disc_d   = perf_disc_q + {31'd0, drop_s};
        perf_starve_d = perf_starve_q + {31'd0, (fetch_ready & ~fetch_valid)};
        if (redirect_valid) begin
            count_d   = ZERO_C;
            rd_ptr_d  = ZERO_P;
            wr_ptr_d  = ZERO_P;
            req_pc_d  = target_s;
            resp_pc_d = target_s;
            discard_d = outstanding_q - (resp_acc_s ? ONE_C : ZERO_C);
        end else begin
            if (req_acc_s) begin
                req_pc_d = req_pc_q + 32'd4;
            end else begin
                req_pc_d = req_pc_q;
            end
            if (drop_s) begin
                discard_d = discard_q - ONE_C;
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                wr_ptr_d  = wr_ptr_q + ONE_P;
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                wr_ptr_d  = wr_ptr_q;
                resp_pc_d = resp_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_P;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
        end
    end

    // Registered head view: new data when it lands in an otherwise empty buffer.
    always_comb begin
        fetch_inst_d = 32'd0;
        fetch_pc_d   = 32'd0;
        if (count_d == ZERO_C) begin
            fetch_inst_d = 32'd0;
            fetch_pc_d   = 32'd0;
        end else if (push_s && (count_q == (pop_s ? ONE_C : ZERO_C))) begin
            fetch_inst_d = Instruction;
            fetch_pc_d   = resp_pc_q;
        end else begin
            fetch_inst_d = mem_inst_q[rd_ptr_d];
            fetch_pc_d   = mem_pc_q[rd_ptr_d];
        end
    end

    // State registers and FIFO storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= ZERO_C;
            discard_q     <= ZERO_C;
            count_q       <= ZERO_C;
            rd_ptr_q      <= ZERO_P;
            wr_ptr_q      <= ZERO_P;
            fetch_inst_q  <= 32'd0;
            fetch_pc_q    <= 32'd0;
            inst_ready_q  <= 1'b0;
            perf_req_q    <= 32'd0;
            perf_disc_q   <= 32'd0;
            perf_starve_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst_q[i] <= 32'd0;
                mem_pc_q[i]   <= 32'd0;
            end
        end else begin
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_pc_q    <= fetch_pc_d;
            inst_ready_q  <= 1'b1;
            perf_req_q    <= perf_req_d;
            perf_disc_q   <= perf_disc_d;
            perf_starve_q <= perf_starve_d;
            if (push_s) begin
                mem_inst_q[wr_ptr_q] <= Instruction;
                mem_pc_q[wr_ptr_q]   <= resp_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit: queue-based reference model, randomized memory/core
// behaviour plus directed scenarios for backpressure, redirects, stalls and reset.
module tb_inst_prefetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready = 1'b0;
    logic [31:0] Instruction = 32'd0;
    logic        Inst_Valid = 1'b0;
    logic        Inst_Ready;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_discard_cnt;
    logic [31:0] perf_starve_cnt;

    int errors = 0;
    int checks = 0;

    inst_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
        .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction), .Inst_Valid(Inst_Valid),
        .Inst_Ready(Inst_Ready), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .perf_req_cnt(perf_req_cnt),
        .perf_discard_cnt(perf_discard_cnt), .perf_starve_cnt(perf_starve_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view only (queues and counts).
    logic [31:0] m_req_pc, m_resp_pc;
    int          m_out, m_disc;
    logic [31:0] mf_inst[$];
    logic [31:0] mf_pc[$];
    logic [31:0] memq[$];
    logic [31:0] m_req_cnt, m_disc_cnt, m_starve_cnt;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit e_req_valid();
        return (rst === 1'b1) && ((mf_pc.size() + m_out) < DEPTH) && !redirect_valid;
    endfunction

    function automatic bit e_fetch_valid();
        return (mf_pc.size() != 0) && !redirect_valid;
    endfunction

    function automatic logic [31:0] e_fetch_inst();
        return (mf_inst.size() != 0) ? mf_inst[0] : 32'd0;
    endfunction

    function automatic logic [31:0] e_fetch_pc();
        return (mf_pc.size() != 0) ? mf_pc[0] : 32'd0;
    endfunction

    task automatic model_reset();
        m_req_pc = RPC; m_resp_pc = RPC; m_out = 0; m_disc = 0;
        mf_inst.delete(); mf_pc.delete(); memq.delete();
        m_req_cnt = 32'd0; m_disc_cnt = 32'd0; m_starve_cnt = 32'd0;
    endtask

    task automatic drive(input bit rq, input bit fr, input bit rv, input logic [31:0] rpc,
                         input int pct);
        @(negedge clk);
        Inst_Req_Ready = rq; fetch_ready = fr; redirect_valid = rv; redirect_pc = rpc;
        if (memq.size() > 0 && int'($urandom_range(99)) < pct) begin
            Inst_Valid = 1'b1; Instruction = inst_of(memq[0]);
        end else begin
            Inst_Valid = 1'b0; Instruction = $urandom;
        end
        #1;
    endtask

    task automatic commit();
        bit          rq_acc, rs, pop, starve, rv;
        logic [31:0] rdata, tgt;
        rq_acc = e_req_valid() && Inst_Req_Ready;
        rs     = Inst_Valid;
        pop    = e_fetch_valid() && fetch_ready;
        starve = fetch_ready && !e_fetch_valid();
        rv     = redirect_valid;
        rdata  = Instruction;
        tgt    = {redirect_pc[31:2], 2'b00};
        @(posedge clk);
        if (starve) m_starve_cnt++;
        if (rq_acc) begin
            memq.push_back(m_req_pc); m_req_pc += 32'd4; m_out++; m_req_cnt++;
        end
        if (rs) void'(memq.pop_front());
        if (rv) begin
            mf_inst.delete(); mf_pc.delete();
            m_req_pc = tgt; m_resp_pc = tgt;
            m_disc = m_out - int'(rs);
            m_out  = m_out - int'(rs);
            if (rs) m_disc_cnt++;
        end else begin
            if (pop) begin void'(mf_inst.pop_front()); void'(mf_pc.pop_front()); end
            if (rs) begin
                m_out--;
                if (m_disc > 0) begin
                    m_disc--; m_disc_cnt++;
                end else begin
                    mf_inst.push_back(rdata); mf_pc.push_back(m_resp_pc); m_resp_pc += 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; Inst_Req_Ready = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
        Inst_Valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({Inst_Req_Valid, Inst_Ready, fetch_valid, fetch_inst, fetch_pc, PC} !==
            {1'b0, 1'b0, 1'b0, 32'd0, 32'd0, RPC}) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b ir=%b fv=%b fi=%h fp=%h pc=%h want 0 0 0 0 0 %h",
                     Inst_Req_Valid, Inst_Ready, fetch_valid, fetch_inst, fetch_pc, PC, RPC);
        end
        checks++;
        if ({perf_req_cnt, perf_discard_cnt, perf_starve_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h want 0", perf_req_cnt, perf_discard_cnt,
                     perf_starve_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (Inst_Req_Valid !== 1'b1 || PC !== RPC) begin
            errors++;
            $display("FAIL first_request: got rv=%b pc=%h want 1 %h", Inst_Req_Valid, PC, RPC);
        end
    endtask

    task automatic test_stream();
        int nreq = 0, nfetch = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
            if (Inst_Req_Valid && Inst_Req_Ready) begin
                checks++;
                if (PC !== 32'(nreq * 4)) begin
                    errors++; $display("FAIL stream_pc: got %h want %h", PC, 32'(nreq * 4));
                end
                nreq++;
            end
            if (fetch_valid) begin
                checks++;
                if (fetch_pc !== 32'(nfetch * 4) || fetch_inst !== inst_of(32'(nfetch * 4))) begin
                    errors++;
                    $display("FAIL stream_fetch: got pc=%h inst=%h want pc=%h", fetch_pc, fetch_inst,
                             32'(nfetch * 4));
                end
                nfetch++;
            end
            commit();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 0);
        checks++;
        if (nreq != 20 || nfetch != 18 || perf_discard_cnt !== 32'd0 || perf_req_cnt !== 32'd20) begin
            errors++;
            $display("FAIL stream_totals: got req=%0d fetch=%0d disc=%0d preq=%0d want 20 18 0 20",
                     nreq, nfetch, perf_discard_cnt, perf_req_cnt);
        end
        commit();
    endtask

    task automatic test_backpressure();
        int  nreq = 0;
        bit  seen = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0, 100);
            if (Inst_Req_Valid && Inst_Req_Ready) nreq++;
            commit();
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 100);
        checks++;
        if (nreq != 4 || Inst_Req_Valid !== 1'b0 || fetch_valid !== 1'b1 || perf_req_cnt !== 32'd4) begin
            errors++;
            $display("FAIL bp_full: got req=%0d rv=%b fv=%b preq=%0d want 4 0 1 4",
                     nreq, Inst_Req_Valid, fetch_valid, perf_req_cnt);
        end
        commit();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
            checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'(k * 4) || fetch_inst !== inst_of(32'(k * 4))) begin
                errors++;
                $display("FAIL bp_pop_order: got fv=%b pc=%h want 1 %h", fetch_valid, fetch_pc,
                         32'(k * 4));
            end
            if (Inst_Req_Valid && !seen) begin
                seen = 1'b1;
                checks++;
                if (PC !== 32'h10) begin
                    errors++; $display("FAIL bp_resume_pc: got %h want 00000010", PC);
                end
            end
            commit();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_resume: got no request want request at 00000010");
        end
    endtask

    task automatic test_redirect();
        bit got = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 32'd0, 0); commit(); end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 100); commit();
        drive(1'b1, 1'b1, 1'b1, 32'h103, 0);
        checks++;
        if (Inst_Req_Valid !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle: got rv=%b fv=%b want 0 0", Inst_Req_Valid, fetch_valid);
        end
        commit();
        drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
        checks++;
        if (PC !== 32'h100 || Inst_Req_Valid !== 1'b1 || fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_next: got pc=%h rv=%b fv=%b want 00000100 1 0", PC, Inst_Req_Valid,
                     fetch_valid);
        end
        commit();
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
            if (fetch_valid) begin
                got = 1'b1;
                checks++;
                if (fetch_pc !== 32'h100 || perf_discard_cnt !== 32'd3) begin
                    errors++;
                    $display("FAIL redir_first_fetch: got pc=%h disc=%0d want 00000100 3", fetch_pc,
                             perf_discard_cnt);
                end
            end
            commit();
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL redir_timeout: got no fetch want fetch of 00000100");
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit got = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 32'd0, 0); commit(); end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 100); commit();
        drive(1'b0, 1'b1, 1'b1, 32'h200, 100);
        checks++;
        if (fetch_valid !== 1'b0 || Inst_Valid !== 1'b1) begin
            errors++; $display("FAIL same_cycle_setup: got fv=%b iv=%b want 0 1", fetch_valid, Inst_Valid);
        end
        commit();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 100);
        checks++;
        if (perf_discard_cnt !== 32'd1 || fetch_valid !== 1'b0 || PC !== 32'h200 || fetch_pc !== 32'd0) begin
            errors++;
            $display("FAIL same_cycle_drop: got disc=%0d fv=%b pc=%h fp=%h want 1 0 00000200 0",
                     perf_discard_cnt, fetch_valid, PC, fetch_pc);
        end
        commit();
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b1, 1'b0, 32'd0, 100); commit(); end
        drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
        checks++;
        if (perf_discard_cnt !== 32'd3 || fetch_valid !== 1'b0 || Inst_Req_Valid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_drain: got disc=%0d fv=%b rv=%b want 3 0 1", perf_discard_cnt,
                     fetch_valid, Inst_Req_Valid);
        end
        commit();
        for (int i = 0; i < 10 && !got; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0, 100);
            if (fetch_valid) begin
                got = 1'b1;
                checks++;
                if (fetch_pc !== 32'h200 || fetch_inst !== inst_of(32'h200)) begin
                    errors++;
                    $display("FAIL same_cycle_fetch: got pc=%h want 00000200", fetch_pc);
                end
            end
            commit();
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL same_cycle_timeout: got no fetch want fetch of 00000200");
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0, 0);
            checks++;
            if (PC !== RPC || Inst_Req_Valid !== 1'b1 || perf_starve_cnt !== 32'(i)) begin
                errors++;
                $display("FAIL stall_hold: got pc=%h rv=%b starve=%0d want %h 1 %0d", PC,
                         Inst_Req_Valid, perf_starve_cnt, RPC, i);
            end
            commit();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 0);
        checks++;
        if (perf_starve_cnt !== 32'd5 || perf_req_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_count: got starve=%0d req=%0d want 5 0", perf_starve_cnt, perf_req_cnt);
        end
        commit();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(99) < 70, $urandom_range(99) < 60, $urandom_range(99) < 5,
                  $urandom, 60);
            checks++;
            if ({PC, Inst_Req_Valid, fetch_valid, fetch_inst, fetch_pc} !==
                {m_req_pc, e_req_valid(), e_fetch_valid(), e_fetch_inst(), e_fetch_pc()}) begin
                errors++;
                $display("FAIL random_out cyc %0d: got pc=%h rv=%b fv=%b fi=%h fp=%h want pc=%h rv=%b fv=%b fi=%h fp=%h",
                         c, PC, Inst_Req_Valid, fetch_valid, fetch_inst, fetch_pc, m_req_pc,
                         e_req_valid(), e_fetch_valid(), e_fetch_inst(), e_fetch_pc());
            end
            checks++;
            if ({perf_req_cnt, perf_discard_cnt, perf_starve_cnt, Inst_Ready} !==
                {m_req_cnt, m_disc_cnt, m_starve_cnt, 1'b1}) begin
                errors++;
                $display("FAIL random_perf cyc %0d: got %0d %0d %0d ir=%b want %0d %0d %0d 1", c,
                         perf_req_cnt, perf_discard_cnt, perf_starve_cnt, Inst_Ready, m_req_cnt,
                         m_disc_cnt, m_starve_cnt);
            end
            commit();
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1, 1'b0, 32'd0, 100); commit(); end
        @(negedge clk);
        rst = 1'b0; Inst_Valid = 1'b0; fetch_ready = 1'b1;
        #1;
        checks++;
        if ({Inst_Req_Valid, Inst_Ready, fetch_valid, fetch_inst, fetch_pc, PC} !==
            {1'b0, 1'b0, 1'b0, 32'd0, 32'd0, RPC} ||
            {perf_req_cnt, perf_discard_cnt, perf_starve_cnt} !== 96'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got rv=%b ir=%b fv=%b fi=%h fp=%h pc=%h req=%0d want 0 0 0 0 0 %h 0",
                     Inst_Req_Valid, Inst_Ready, fetch_valid, fetch_inst, fetch_pc, PC, perf_req_cnt, RPC);
        end
        @(negedge clk);
        rst = 1'b1; fetch_ready = 1'b0;
        model_reset();
        #1;
        checks++;
        if (PC !== RPC || Inst_Req_Valid !== 1'b1 || perf_req_cnt !== 32'd0 ||
            perf_discard_cnt !== 32'd0 || perf_starve_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midreset_restart: got pc=%h rv=%b cnt=%0d/%0d/%0d want %h 1 0/0/0", PC,
                     Inst_Req_Valid, perf_req_cnt, perf_discard_cnt, perf_starve_cnt, RPC);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_req_stall();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_unit.md
# inst_prefetch_unit

Parametrised instruction prefetch unit between the multi-cycle core and the instruction memory channels. Keeps up to DEPTH instruction requests in flight and DEPTH fetched instructions buffered in order. It presents them to the core through a valid/ready fetch port and handles control-flow redirects by flushing the buffer and discarding stale responses. It is a drop-in front end that lets a later core overlap fetch with execute.

## Interface
- DEPTH, 4: buffer entries and maximum in-flight requests; power of two, 2..16.
- RESET_PC, 32'h0: first fetch address after reset; bits [1:0] must be 0.
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- PC  out  32  instruction request address, word-aligned.
- Inst_Req_Valid  out  1  request valid.
- Inst_Req_Ready  in  1  memory accepts request.
- Instruction  in  32  response data.
- Inst_Valid  in  1  response valid.
- Inst_Ready  out  1  response accept.
- fetch_valid  out  1  fetch_inst/fetch_pc valid to core.
- fetch_ready  in  1  core consumes head entry.
- fetch_inst  out  32  head instruction.
- fetch_pc  out  32  address of head instruction.
- redirect_valid  in  1  core requests restart at redirect_pc (branch/jump taken).
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0.
- perf_req_cnt  out  32  accepted requests.
- perf_discard_cnt  out  32  dropped stale responses.
- perf_starve_cnt  out  32  cycles with fetch_ready=1 and fetch_valid=0.

## Operation
- State: req_pc (32), resp_pc (32), outstanding (clog2(DEPTH)+1 bits), discard (same width), FIFO of DEPTH {inst, pc} entries with count, rd/wr pointers wrapping mod DEPTH.
- Credit rule: Inst_Req_Valid = (count + outstanding < DEPTH) && !redirect_valid. Because space is reserved at request time, the FIFO never overflows and Inst_Ready is constant 1 out of reset.
- Request accept (Inst_Req_Valid && Inst_Req_Ready): req_pc += 4 (wraps mod 2^32), outstanding++. PC = req_pc. A pending, unaccepted request holds PC stable. It is withdrawn only on a redirect cycle.
- Response accept (Inst_Valid && Inst_Ready): outstanding--. If discard > 0, the response is dropped, discard--, and perf_discard_cnt++. Otherwise it pushes {Instruction, resp_pc} and resp_pc += 4. Responses return in request order.
- Pop: fetch_valid = (count != 0) && !redirect_valid. fetch_valid && fetch_ready pops the head. fetch_inst and fetch_pc are the head entry, or 0 when the FIFO is empty.
- Same-cycle push and pop: count unchanged, both pointers advance.
- Redirect (redirect_valid=1), with priority over push, pop and request:
  - FIFO flushed (count=0, pointers=0).
  - req_pc and resp_pc are set to {redirect_pc[31:2],2'b00}.
  - discard is set to outstanding (the pre-update value, including any in-flight response); outstanding is then reduced by 1 if a response is accepted that cycle, and that response is also dropped.
  - A response accepted in the redirect cycle therefore decrements both outstanding and discard and increments perf_discard_cnt.
- Back-to-back redirects: each one reloads the PCs and sets discard to the current outstanding.
- Perf counters: 32-bit, wrap, never cleared except by reset.

## Timing
- Reset (rst=0): req_pc=resp_pc=RESET_PC; outstanding, discard, count, pointers and all counters 0. Outputs during reset: Inst_Req_Valid=0, Inst_Ready=0, fetch_valid=0, fetch_inst=0, fetch_pc=0, PC=RESET_PC.
- First cycle after rst rises: Inst_Req_Valid=1, PC=RESET_PC.
- Throughput: one request per cycle while credits remain; one response accepted per cycle.
- Response-to-fetch latency: a response accepted at edge N gives fetch_valid=1 in cycle N+1. There is no combinational bypass.
- Redirect asserted in cycle N: Inst_Req_Valid=0 and fetch_valid=0 in cycle N. In cycle N+1, PC=redirect target and Inst_Req_Valid=1 if outstanding < DEPTH.
- All outputs except Inst_Req_Valid and fetch_valid (which also depend on redirect_valid) are register-driven.
- Reset asserted mid-operation: all state clears immediately. Responses arriving after reset release are not tracked, because outstanding=0. The memory side must be reset together with this block.

## Test plan
- Zero-wait memory, DEPTH=4, fetch_ready=1: PC sequence 0,4,8,… one per cycle. fetch_pc matches each accepted response, one cycle later. perf_discard_cnt=0.
- fetch_ready=0, memory always ready: exactly 4 requests are accepted (PC 0..0xC), then Inst_Req_Valid=0. count=4. Releasing fetch_ready pops in order 0,4,8,C, and requests resume at 0x10.
- 3 requests outstanding, 1 buffered, then redirect_pc=0x103: FIFO emptied and the next PC is 0x100. The next 3 responses are dropped, so perf_discard_cnt=3. The first fetch_pc delivered is 0x100.
- Redirect in the same cycle as a response accept and a pop: the response is dropped, the pop is ignored, and discard equals the prior outstanding minus 1 after that cycle.
- Memory with Inst_Req_Ready low for 5 cycles: PC is held stable and perf_starve_cnt increments every cycle that fetch_ready=1 with the FIFO empty.
- rst pulsed low mid-stream: all outputs return to their reset values in the same cycle. After release, the PC restarts at RESET_PC and the counters read 0.
